alu_iter: RTL
=============

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width taken from opB[SHW-1:0].
REQ-003 Port clk  in  1  single clock; all state on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port in_valid  in  1  request present.
REQ-006 Port in_ready  out  1  block accepts a request this cycle.
REQ-007 Port opA  in  XLEN  operand A.
REQ-008 Port opB  in  XLEN  operand B.
REQ-009 Port aluOutSel  in  4  operation select.
REQ-010 Port out_valid  out  1  result available.
REQ-011 Port out_ready  in  1  consumer takes result.
REQ-012 Port aluOut  out  XLEN  registered result.
REQ-013 Port out_err  out  1  unsupported aluOutSel; qualified by out_valid.

Function
REQ-014 Op codes SHALL be: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 slt (signed), 6 sltu (unsigned), 7 sll, 8 srl, 9 sra, 10 mul (low XLEN bits; only with macro), 15 pass opA; all others are illegal.
REQ-015 Add/sub SHALL wrap modulo 2^XLEN; slt/sltu SHALL return 1 or 0 zero-extended to XLEN.
REQ-016 FSM states SHALL be IDLE, SHIFT, MUL, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept occurs when in_valid && in_ready; operands and op SHALL be latched on accept and later input changes SHALL be ignored.
REQ-018 Ops 0-6, 15, and illegal ops: IDLE->DONE; out_valid SHALL assert the cycle after accept (latency 1).
REQ-019 Shifts SHALL shift one bit per cycle in SHIFT; shamt=0 goes IDLE->DONE (latency 1); otherwise latency SHALL be 1+shamt, with shamt XLEN-1 giving latency XLEN.
REQ-020 sra SHALL replicate the latched sign bit each step; srl/sll SHALL shift in 0.
REQ-021 Illegal ops SHALL produce aluOut=0 and out_err=1; legal ops SHALL produce out_err=0.
REQ-022 In DONE, aluOut/out_err SHALL stay stable until out_valid && out_ready; then go to IDLE, with in_ready=1 the next cycle (no accept in the handshake cycle).
REQ-023 out_ready asserted before out_valid SHALL have no effect; back-pressure may last indefinitely.

Reset
REQ-024 rst SHALL force IDLE, in_ready=1 on the following cycle, out_valid=0, out_err=0, aluOut=0, and shift/mul counters=0.
REQ-025 rst asserted mid-operation (SHIFT, MUL, DONE) SHALL abort the operation without emitting a result; rst SHALL take priority over any handshake in the same cycle.

Configuration
REQ-026 Macro ALU_ITER_MUL_EN defined: op 10 SHALL be a shift-add multiply, IDLE->MUL for exactly XLEN cycles, then DONE; latency XLEN+1; result SHALL be the low XLEN bits of the unsigned product (low bits are sign-independent).
REQ-027 Macro ALU_ITER_MUL_EN undefined: op 10 SHALL be illegal per REQ-021, and no MUL state or multiplier logic SHALL be synthesised.

Structure
REQ-028 Package alu_iter_pkg SHALL hold the op-code enum (4-bit), the FSM state enum, and the default XLEN constant.
REQ-029 Sub-module alu_iter_seq SHALL hold the shift/multiply datapath (accumulator, operand shift regs, step counter); the top-level SHALL hold the FSM, handshake, and single-cycle ops.

Verification
REQ-030 XLEN=32: add 0xFFFFFFFF+0x1 -> aluOut=0x0, out_valid 1 cycle after accept; slt 0xFFFFFFFF,0x1 -> 1; sltu on same operands -> 0.
REQ-031 sra opA=0x80000000 by 31 -> 0xFFFFFFFF, out_valid exactly 32 cycles after accept; sll by 0 -> opA after 1 cycle.
REQ-032 Result 0x5, out_ready held low 10 cycles -> aluOut stable, in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
REQ-033 rst pulsed at cycle 5 of a 20-step srl -> no out_valid, outputs zero, in_ready=1 the cycle after rst drops.
REQ-034 Op 0xC -> out_err=1, aluOut=0; op 10 with the macro: 0xFFFF*0x10001 -> 0xFFFFFFFF at latency 33; op 10 without the macro -> out_err=1.
REQ-035 Repeat REQ-030 and REQ-031 at XLEN=8 and XLEN=64: sra 0x80 by 7 -> 0xFF at latency 8.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// Shared op-codes, FSM states and defaults for the iterative ALU.
package alu_iter_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10,
        OP_PASS = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MUL,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SEQ_SLL,
        SEQ_SRL,
        SEQ_SRA,
        SEQ_MUL
    } seq_mode_e;

endpackage

// File: rtl/alu_iter_seq.sv
// Multi-cycle datapath for the iterative ALU: one shift step (or one shift-add
// multiply step) per cycle. Multiply hardware exists only with ALU_ITER_MUL_EN.
module alu_iter_seq
    import alu_iter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [1:0]      mode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [SHW-1:0]  shamt,
    output logic            last,
    output logic [XLEN-1:0] next_val
);

    seq_mode_e       mode_q;
    logic [XLEN-1:0] data_q;
    logic [SHW:0]    cnt;

`ifdef ALU_ITER_MUL_EN
    localparam logic [SHW:0] CNT_FULL = (SHW+1)'(XLEN);
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] mplier_q;
`else
    logic unused_b;
    assign unused_b = ^b;
`endif

    assign last = (cnt == (SHW+1)'(1));

    // next_val is what the register holds after this step; the top latches it on the final step
    always_comb begin
        next_val = data_q;
        case (mode_q)
            SEQ_SLL: next_val = data_q << 1;
            SEQ_SRL: next_val = data_q >> 1;
            SEQ_SRA: next_val = {data_q[XLEN-1], data_q[XLEN-1:1]};
`ifdef ALU_ITER_MUL_EN
            SEQ_MUL: next_val = acc_q + (mplier_q[0] ? data_q : '0);
`endif
            default: next_val = data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= SEQ_SLL;
            data_q   <= '0;
            cnt      <= '0;
`ifdef ALU_ITER_MUL_EN
            acc_q    <= '0;
            mplier_q <= '0;
`endif
        end else if (load) begin
            mode_q <= seq_mode_e'(mode);
            data_q <= a;
            cnt    <= {1'b0, shamt};
`ifdef ALU_ITER_MUL_EN
            acc_q    <= '0;
            mplier_q <= b;
            if (seq_mode_e'(mode) == SEQ_MUL) cnt <= CNT_FULL;
`endif
        end else if (step) begin
            cnt <= cnt - (SHW+1)'(1);
`ifdef ALU_ITER_MUL_EN
            if (mode_q == SEQ_MUL) begin
                acc_q    <= next_val;
                data_q   <= data_q << 1;
                mplier_q <= mplier_q >> 1;
            end else begin
                data_q <= next_val;
            end
`else
            data_q <= next_val;
`endif
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU with valid/ready handshakes; single-cycle ops finish in one cycle,
// shifts step one bit per cycle. Define ALU_ITER_MUL_EN to enable op 10 (multiply).
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [3:0]      aluOutSel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluOut,
    output logic            out_err
);

    state_e          state;
    op_e             op_sel;
    seq_mode_e       seq_mode;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] comb_val;
    logic            comb_err;
    logic            is_shift;
    logic            is_mul;
    logic            accept;
    logic            seq_last;
    logic [XLEN-1:0] seq_next;

    assign op_sel = op_e'(aluOutSel);
    assign shamt  = opB[SHW-1:0];
    assign accept = (state == IDLE) && in_valid;

    // Shift ops with a zero amount fall through here as a plain copy of opA
    always_comb begin
        comb_val = '0;
        comb_err = 1'b0;
        is_shift = 1'b0;
        is_mul   = 1'b0;
        seq_mode = SEQ_SLL;
        case (op_sel)
            OP_ADD:  comb_val = opA + opB;
            OP_SUB:  comb_val = opA - opB;
            OP_XOR:  comb_val = opA ^ opB;
            OP_OR:   comb_val = opA | opB;
            OP_AND:  comb_val = opA & opB;
            OP_SLT:  comb_val = XLEN'($signed(opA) < $signed(opB));
            OP_SLTU: comb_val = XLEN'(opA < opB);
            OP_SLL: begin
                comb_val = opA;
                is_shift = 1'b1;
                seq_mode = SEQ_SLL;
            end
            OP_SRL: begin
                comb_val = opA;
                is_shift = 1'b1;
                seq_mode = SEQ_SRL;
            end
            OP_SRA: begin
                comb_val = opA;
                is_shift = 1'b1;
                seq_mode = SEQ_SRA;
            end
`ifdef ALU_ITER_MUL_EN
            OP_MUL: begin
                is_mul   = 1'b1;
                seq_mode = SEQ_MUL;
            end
`endif
            OP_PASS: comb_val = opA;
            default: comb_err = 1'b1;
        endcase
    end

    alu_iter_seq #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     ((state == SHIFT) || (state == MUL)),
        .mode     (seq_mode),
        .a        (opA),
        .b        (opB),
        .shamt    (shamt),
        .last     (seq_last),
        .next_val (seq_next)
    );

    // Outputs are registered alongside the state so in_ready/out_valid never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            aluOut    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_shift && (shamt != '0)) begin
                            state <= SHIFT;
                        end else if (is_mul) begin
                            state <= MUL;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            aluOut    <= comb_val;
                            out_err   <= comb_err;
                        end
                    end
                end
`ifdef ALU_ITER_MUL_EN
                SHIFT, MUL: begin
`else
                SHIFT: begin
`endif
                    if (seq_last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        aluOut    <= seq_next;
                        out_err   <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
